// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty controller.
//   - state_t: button-sequencing FSM states
//   - BTN_*: index of each button in the conditioned button vector
//   - step_of(): signed duty step for a button index, given the fine and
//     coarse step magnitudes chosen by the instantiating module
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam int NUM_BTN = 4;

    localparam logic [1:0] BTN_INC  = 2'd0;
    localparam logic [1:0] BTN_INC1 = 2'd1;
    localparam logic [1:0] BTN_DEC  = 2'd2;
    localparam logic [1:0] BTN_DEC1 = 2'd3;

    // Per-button step table: direction and whether the coarse magnitude applies.
    localparam int STEP_SIGN      [NUM_BTN] = '{1, 1, -1, -1};
    localparam bit STEP_IS_COARSE [NUM_BTN] = '{1'b0, 1'b1, 1'b0, 1'b1};

    function automatic int step_of(input logic [1:0] idx, input int fine, input int coarse);
        int mag;
        mag = STEP_IS_COARSE[idx] ? coarse : fine;
        return STEP_SIGN[idx] * mag;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw, asynchronous, active-low push button.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset (button reads as released)
//   btn_n_i  raw button level, active-low, asynchronous
//   level_o  debounced level; 0 = pressed
// The debounced level only follows the synchronised input once the two have
// disagreed for DB_CYCLES consecutive cycles; any agreement restarts the count.
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_n_i,
    output logic level_o
);

    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // Two-flop synchroniser followed by the stability counter. The counter
    // holds the number of consecutive cycles already seen with a mismatch,
    // so the level flips on the DB_CYCLES-th mismatching cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Push-button PWM duty controller.
// Ports:
//   clkin         system clock
//   reset         synchronous active-high reset
//   inc/inc1      raw active-low buttons: +STEP_FINE / +STEP_COARSE
//   dec/dec1      raw active-low buttons: -STEP_FINE / -STEP_COARSE
//   duty          target duty (feeds the display)
//   duty_active   duty in force for the current PWM period
//   count         period counter, 0..PERIOD-1
//   pwm           PWM output, high while count < duty_active
//   period_start  high while count == PERIOD-1
//   sat           one-cycle pulse when a step result was clamped
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PERIOD        = 50,
    parameter int W             = 8,
    parameter int DUTY_INIT     = 0,
    parameter int STEP_FINE     = 1,
    parameter int STEP_COARSE   = 5,
    parameter int DB_CYCLES     = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic         clkin,
    input  logic         reset,
    input  logic         inc,
    input  logic         inc1,
    input  logic         dec,
    input  logic         dec1,
    output logic [W-1:0] duty,
    output logic [W-1:0] duty_active,
    output logic [W-1:0] count,
    output logic         pwm,
    output logic         period_start,
    output logic         sat
);

    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]       HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]       REPEAT_LOAD = TW'(REPEAT_CYCLES - 1);
    localparam logic [W-1:0]        DUTY_RST    = W'(DUTY_INIT);
    localparam logic [W-1:0]        COUNT_LAST  = W'(PERIOD - 1);
    localparam logic [W-1:0]        DUTY_MAX    = W'(PERIOD);
    localparam logic signed [W:0]   PERIOD_S    = (W+1)'(PERIOD);

    logic [NUM_BTN-1:0] btnRaw;
    logic [NUM_BTN-1:0] btnLevel;
    logic [NUM_BTN-1:0] pressed;
    logic [2:0]         npress;
    logic [1:0]         pressIdx;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      held_q, held_d;
    logic [W-1:0]    duty_q, duty_d;
    logic            sat_q, sat_d;
    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    duty_active_q, duty_active_d;

    logic            doStep;
    logic signed [W:0] stepVal;
    logic signed [W:0] stepSum;
    logic [W-1:0]    stepRes;
    logic            clipped;

    assign btnRaw[BTN_INC]  = inc;
    assign btnRaw[BTN_INC1] = inc1;
    assign btnRaw[BTN_DEC]  = dec;
    assign btnRaw[BTN_DEC1] = dec1;

    for (genvar g = 0; g < NUM_BTN; g++) begin : gen_db
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk_i  (clkin),
            .reset_i(reset),
            .btn_n_i(btnRaw[g]),
            .level_o(btnLevel[g])
        );
    end

    assign pressed = ~btnLevel;

    // Number of pressed buttons and the index of one of them; the index is
    // only meaningful when exactly one button is down.
    always_comb begin
        npress   = '0;
        pressIdx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            npress = npress + {2'b00, pressed[i]};
            if (pressed[i]) begin
                pressIdx = 2'(i);
            end
        end
    end

    // Button sequencing. A different single button appearing while one is
    // held counts as a release, so the newcomer is stepped from IDLE on the
    // next cycle with a fresh hold delay.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        held_d  = held_q;
        doStep  = 1'b0;
        case (state_q)
            IDLE: begin
                if (npress == 3'd1) begin
                    doStep  = 1'b1;
                    held_d  = pressIdx;
                    timer_d = HOLD_LOAD;
                    state_d = HOLD;
                end else if (npress > 3'd1) begin
                    state_d = LOCKOUT;
                end
            end
            HOLD, REPEAT: begin
                if (npress > 3'd1) begin
                    state_d = LOCKOUT;
                end else if (npress == 3'd0 || pressIdx != held_q) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    doStep  = 1'b1;
                    timer_d = REPEAT_LOAD;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOCKOUT: begin
                if (npress == 3'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Step arithmetic in one extra signed bit so both overshoot directions
    // are visible before clamping to 0..PERIOD.
    always_comb begin
        stepVal = (W+1)'(step_of(pressIdx, STEP_FINE, STEP_COARSE));
        stepSum = $signed({1'b0, duty_q}) + stepVal;
        clipped = 1'b0;
        if (stepSum[W]) begin
            stepRes = '0;
            clipped = 1'b1;
        end else if (stepSum > PERIOD_S) begin
            stepRes = DUTY_MAX;
            clipped = 1'b1;
        end else begin
            stepRes = stepSum[W-1:0];
        end
        duty_d = doStep ? stepRes : duty_q;
        sat_d  = doStep & clipped;
    end

    // Period counter and shadow duty: the new duty is only taken on the
    // wrap edge, so every output period runs to completion.
    always_comb begin
        period_start  = (count_q == COUNT_LAST);
        count_d       = period_start ? '0 : count_q + W'(1);
        duty_active_d = period_start ? duty_q : duty_active_q;
    end

    // State registers.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            held_q        <= '0;
            duty_q        <= DUTY_RST;
            sat_q         <= 1'b0;
            count_q       <= '0;
            duty_active_q <= DUTY_RST;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            held_q        <= held_d;
            duty_q        <= duty_d;
            sat_q         <= sat_d;
            count_q       <= count_d;
            duty_active_q <= duty_active_d;
        end
    end

    assign duty        = duty_q;
    assign duty_active = duty_active_q;
    assign count       = count_q;
    assign sat         = sat_q;
    assign pwm         = (count_q < duty_active_q);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl with short debounce/hold/repeat times.
// Expected duty values come from a press-level model: a clean hold of L
// cycles produces one step at acceptance plus auto-repeats, each clamped.
module tb_pwm_duty_ctrl;

    localparam int PERIOD = 50;
    localparam int W      = 8;
    localparam int DB     = 4;
    localparam int HOLD   = 20;
    localparam int REP    = 5;

    logic         clkin = 1'b0;
    logic         reset = 1'b1;
    logic         incN  = 1'b1;
    logic         inc1N = 1'b1;
    logic         decN  = 1'b1;
    logic         dec1N = 1'b1;
    logic [W-1:0] duty;
    logic [W-1:0] dutyActive;
    logic [W-1:0] count;
    logic         pwm;
    logic         periodStart;
    logic         sat;

    int checks   = 0;
    int failures = 0;
    int satSeen  = 0;
    int modelDuty = 0;
    int modelSat  = 0;
    int stepTable [4] = '{1, 5, -1, -5};

    pwm_duty_ctrl #(
        .PERIOD(PERIOD), .W(W), .DUTY_INIT(0), .STEP_FINE(1), .STEP_COARSE(5),
        .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .inc         (incN),
        .inc1        (inc1N),
        .dec         (decN),
        .dec1        (dec1N),
        .duty        (duty),
        .duty_active (dutyActive),
        .count       (count),
        .pwm         (pwm),
        .period_start(periodStart),
        .sat         (sat)
    );

    always #5 clkin = ~clkin;

    // Count every sat pulse seen.
    always @(negedge clkin) begin
        if (sat === 1'b1) satSeen++;
    end

    // duty_active may only move on the edge that ends a period or under reset.
    logic [W-1:0] lastDa = '0;
    logic         lastPs = 1'b0;
    logic         lastReset = 1'b1;
    always @(negedge clkin) begin
        if (!lastReset && dutyActive !== lastDa) begin
            checks++;
            if (lastPs !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dutyActiveTiming: changed %0d -> %0d without period_start", lastDa, dutyActive);
            end
        end
        lastDa    = dutyActive;
        lastPs    = periodStart;
        lastReset = reset;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic setBtn(input int btn, input logic v);
        case (btn)
            0: incN  = v;
            1: inc1N = v;
            2: decN  = v;
            default: dec1N = v;
        endcase
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic applyReset;
        reset = 1'b1;
        incN = 1'b1; inc1N = 1'b1; decN = 1'b1; dec1N = 1'b1;
        cycles(2);
        reset = 1'b0;
        modelDuty = 0;
    endtask

    // Clean press of len cycles, then enough idle time for release to settle.
    task automatic applyStimulus(input int btn, input int len);
        setBtn(btn, 1'b0);
        cycles(len);
        setBtn(btn, 1'b1);
        cycles(12);
    endtask

    // Reference: one step on acceptance, one after HOLD cycles held, then one
    // every REP cycles, each clamped to 0..PERIOD.
    task automatic modelPress(input int btn, input int len);
        int n;
        int v;
        n = 1 + ((len > HOLD) ? 1 + (len - HOLD - 1) / REP : 0);
        for (int k = 0; k < n; k++) begin
            v = modelDuty + stepTable[btn];
            if (v > PERIOD) begin v = PERIOD; modelSat++; end
            else if (v < 0) begin v = 0; modelSat++; end
            modelDuty = v;
        end
    endtask

    task automatic waitBoundary(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < PERIOD + 5 && !ok; i++) begin
            @(negedge clkin);
            if (periodStart === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clkin); #1;
        checks++; if (count !== 0) begin failures++; $display("[TB] FAIL resetCount: got %0d expected 0", count); end
        checks++; if (duty !== 0) begin failures++; $display("[TB] FAIL resetDuty: got %0d expected 0", duty); end
        checks++; if (dutyActive !== 0) begin failures++; $display("[TB] FAIL resetDutyActive: got %0d expected 0", dutyActive); end
        checks++; if (sat !== 1'b0) begin failures++; $display("[TB] FAIL resetSat: got %b expected 0", sat); end
        checks++; if (periodStart !== 1'b0) begin failures++; $display("[TB] FAIL resetPeriodStart: got %b expected 0", periodStart); end
        checks++; if (pwm !== 1'b0) begin failures++; $display("[TB] FAIL resetPwm: got %b expected 0", pwm); end
        @(posedge clkin); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_step;
        bit ok;
        int highs;
        int s0;
        applyReset;
        s0 = satSeen;
        incN = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clkin); #1;
            if (i == 6) begin
                checks++; if (duty !== 0) begin failures++; $display("[TB] FAIL basicBeforeLatency: got %0d expected 0", duty); end
            end
            if (i == 7) begin
                checks++; if (duty !== 1) begin failures++; $display("[TB] FAIL basicAtLatency: got %0d expected 1", duty); end
            end
        end
        incN = 1'b1;
        cycles(12);
        checks++; if (duty !== 1) begin failures++; $display("[TB] FAIL basicSingleStep: got %0d expected 1", duty); end
        checks++; if (satSeen != s0) begin failures++; $display("[TB] FAIL basicNoSat: got %0d expected %0d", satSeen, s0); end
        waitBoundary(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL basicBoundary: got timeout expected period_start"); end
        checks++; if (dutyActive !== 1) begin failures++; $display("[TB] FAIL basicDutyActive: got %0d expected 1", dutyActive); end
        highs = 0;
        repeat (PERIOD) begin
            @(negedge clkin);
            if (pwm === 1'b1) highs++;
        end
        checks++; if (highs != 1) begin failures++; $display("[TB] FAIL basicPwmHigh: got %0d expected 1", highs); end
    endtask

    task automatic test_bounce;
        int d0;
        int s0;
        d0 = int'(duty);
        s0 = satSeen;
        for (int i = 0; i < 40; i++) begin
            dec1N = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            cycles(1);
        end
        dec1N = 1'b1;
        cycles(12);
        checks++; if (int'(duty) != d0) begin failures++; $display("[TB] FAIL bounceDuty: got %0d expected %0d", duty, d0); end
        checks++; if (satSeen != s0) begin failures++; $display("[TB] FAIL bounceSat: got %0d expected %0d", satSeen, s0); end
    endtask

    task automatic test_auto_repeat;
        int stepEdges [5] = '{7, 27, 32, 37, 42};
        int expDuty;
        int s0;
        applyReset;
        s0 = satSeen;
        inc1N = 1'b0;
        for (int i = 1; i <= 55; i++) begin
            @(posedge clkin); #1;
            if (i == 40) inc1N = 1'b1;
            expDuty = 0;
            for (int k = 0; k < 5; k++) if (stepEdges[k] <= i) expDuty += 5;
            checks++;
            if (int'(duty) != expDuty) begin
                failures++;
                $display("[TB] FAIL repeatDuty@%0d: got %0d expected %0d", i, duty, expDuty);
            end
        end
        checks++; if (satSeen != s0) begin failures++; $display("[TB] FAIL repeatSat: got %0d expected %0d", satSeen, s0); end
    endtask

    task automatic test_sat_top;
        bit ok;
        int s0;
        int highs;
        applyReset;
        applyStimulus(1, 60); modelPress(1, 60);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 8); modelPress(0, 8);
        end
        checks++; if (int'(duty) != modelDuty || modelDuty != 48) begin failures++; $display("[TB] FAIL topSetup: got %0d expected 48", duty); end
        s0 = satSeen;
        inc1N = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clkin); #1;
            if (i == 7) begin
                checks++; if (duty !== 50) begin failures++; $display("[TB] FAIL topClampDuty: got %0d expected 50", duty); end
                checks++; if (sat !== 1'b1) begin failures++; $display("[TB] FAIL topSatPulse: got %b expected 1", sat); end
            end
            if (i == 8) begin
                checks++; if (sat !== 1'b0) begin failures++; $display("[TB] FAIL topSatOneCycle: got %b expected 0", sat); end
            end
        end
        inc1N = 1'b1;
        cycles(12);
        checks++; if (duty !== 50) begin failures++; $display("[TB] FAIL topHoldDuty: got %0d expected 50", duty); end
        checks++; if (satSeen - s0 != 5) begin failures++; $display("[TB] FAIL topSatRepeats: got %0d expected 5", satSeen - s0); end
        waitBoundary(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL topBoundary: got timeout expected period_start"); end
        highs = 0;
        repeat (PERIOD) begin
            @(negedge clkin);
            if (pwm === 1'b1) highs++;
        end
        checks++; if (highs != PERIOD) begin failures++; $display("[TB] FAIL topPwmHigh: got %0d expected %0d", highs, PERIOD); end
    endtask

    task automatic test_sat_bottom_lockout;
        int s0;
        applyReset;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 8); modelPress(0, 8);
        end
        checks++; if (duty !== 3) begin failures++; $display("[TB] FAIL bottomSetup: got %0d expected 3", duty); end
        s0 = satSeen;
        applyStimulus(3, 8);
        checks++; if (duty !== 0) begin failures++; $display("[TB] FAIL bottomClamp: got %0d expected 0", duty); end
        checks++; if (satSeen - s0 != 1) begin failures++; $display("[TB] FAIL bottomSat: got %0d expected 1", satSeen - s0); end
        s0 = satSeen;
        incN = 1'b0;
        decN = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            cycles(1);
            if (i == 20) incN = 1'b1;
        end
        decN = 1'b1;
        cycles(12);
        checks++; if (duty !== 0) begin failures++; $display("[TB] FAIL lockoutDuty: got %0d expected 0", duty); end
        checks++; if (satSeen != s0) begin failures++; $display("[TB] FAIL lockoutSat: got %0d expected %0d", satSeen, s0); end
        applyStimulus(0, 8);
        checks++; if (duty !== 1) begin failures++; $display("[TB] FAIL lockoutExit: got %0d expected 1", duty); end
    endtask

    task automatic test_shadow_and_reset;
        bit found;
        int s0;
        applyReset;
        found = 1'b0;
        for (int i = 0; i < PERIOD + 5 && !found; i++) begin
            cycles(1);
            if (count === 3) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("[TB] FAIL shadowAlign: got timeout expected count 3"); end
        inc1N = 1'b0;
        for (int i = 1; i <= 47; i++) begin
            cycles(1);
            if (i == 8) inc1N = 1'b1;
            if (i == 7) begin
                checks++; if (count !== 10) begin failures++; $display("[TB] FAIL shadowCount: got %0d expected 10", count); end
                checks++; if (duty !== 5) begin failures++; $display("[TB] FAIL shadowDuty: got %0d expected 5", duty); end
                checks++; if (dutyActive !== 0) begin failures++; $display("[TB] FAIL shadowEarly: got %0d expected 0", dutyActive); end
            end
            if (i == 46) begin
                checks++; if (dutyActive !== 0 || count !== 49) begin failures++; $display("[TB] FAIL shadowLastCycle: got da=%0d cnt=%0d expected da=0 cnt=49", dutyActive, count); end
            end
            if (i == 47) begin
                checks++; if (dutyActive !== 5 || count !== 0) begin failures++; $display("[TB] FAIL shadowTaken: got da=%0d cnt=%0d expected da=5 cnt=0", dutyActive, count); end
            end
        end
        incN = 1'b0;
        cycles(30);
        checks++; if (duty !== 7) begin failures++; $display("[TB] FAIL repeatBeforeReset: got %0d expected 7", duty); end
        reset = 1'b1;
        incN  = 1'b1;
        cycles(1);
        reset = 1'b0;
        modelDuty = 0;
        checks++; if (count !== 0 || duty !== 0 || dutyActive !== 0 || sat !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midRepeatReset: got cnt=%0d duty=%0d da=%0d sat=%b expected all 0", count, duty, dutyActive, sat);
        end
        s0 = satSeen;
        cycles(30);
        checks++; if (duty !== 0 || satSeen != s0) begin failures++; $display("[TB] FAIL afterReset: got duty=%0d sats=%0d expected 0/0", duty, satSeen - s0); end
        incN = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cycles(1);
            if (i == 6) begin
                checks++; if (duty !== 0) begin failures++; $display("[TB] FAIL idleBefore: got %0d expected 0", duty); end
            end
            if (i == 7) begin
                checks++; if (duty !== 1) begin failures++; $display("[TB] FAIL idleStep: got %0d expected 1", duty); end
            end
        end
        incN = 1'b1;
        cycles(12);
    endtask

    task automatic test_random;
        bit ok;
        int btn;
        int len;
        int s0;
        applyReset;
        s0 = satSeen;
        modelSat = 0;
        for (int it = 0; it < 14; it++) begin
            btn = int'($urandom_range(0, 3));
            len = int'($urandom_range(5, 60));
            applyStimulus(btn, len);
            modelPress(btn, len);
            checks++;
            if (int'(duty) != modelDuty) begin failures++; $display("[TB] FAIL randomDuty[%0d] btn=%0d len=%0d: got %0d expected %0d", it, btn, len, duty, modelDuty); end
            checks++;
            if (satSeen - s0 != modelSat) begin failures++; $display("[TB] FAIL randomSat[%0d]: got %0d expected %0d", it, satSeen - s0, modelSat); end
        end
        waitBoundary(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL randomBoundary: got timeout expected period_start"); end
        checks++; if (int'(dutyActive) != modelDuty) begin failures++; $display("[TB] FAIL randomDutyActive: got %0d expected %0d", dutyActive, modelDuty); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset;
        test_basic_step;
        test_bounce;
        test_auto_repeat;
        test_sat_top;
        test_sat_bottom_lockout;
        test_shadow_and_reset;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
